piezo_alert_sequencer: RTL and testbench

Prioritised audio sequencer that drives the single piezo buzzer. It replaces the plain OR of the timer beep and the Event 1 warning at the top level. It arbitrates level-type alerts (timer beep, overload warning) and one-shot cue patterns (puzzle correct, bomb defused, explosion), then generates a registered square-wave tone on `piezo_out`. It sits downstream of the piezo timer-alert counter, `event1_overload`, and `main_fsm`, and upstream of the piezo pin.

---
 rtl/piezo_alert_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_piezo_alert_sequencer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/piezo_alert_sequencer.sv
// Prioritised piezo alert sequencer: arbitrates level alerts and one-shot cue
// patterns and drives a registered square-wave tone on piezo_out.
module piezo_alert_sequencer #(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned TONE_HI_HZ  = 2000,
  parameter int unsigned TONE_LO_HZ  = 1000,
  parameter int unsigned NOTE_TICKS  = 5_000_000
) (
  input  logic       clk,
  input  logic       sys_rst,
  input  logic       enable,
  input  logic       beep_level,
  input  logic       warn_level,
  input  logic       ok_pulse,
  input  logic       win_pulse,
  input  logic       lose_pulse,
  output logic       piezo_out,
  output logic       busy,
  output logic [2:0] pattern_id
);

  localparam int unsigned HALF_HI = CLK_FREQ_HZ / (2 * TONE_HI_HZ);
  localparam int unsigned HALF_LO = CLK_FREQ_HZ / (2 * TONE_LO_HZ);

  typedef enum logic [1:0] {S_IDLE, S_LEVEL, S_ONESHOT} state_e;
  typedef enum logic [1:0] {C_SIL, C_LO, C_HI} code_e;
  typedef enum logic [2:0] {
    P_IDLE = 3'd0, P_BEEP = 3'd1, P_WARN = 3'd2,
    P_OK   = 3'd3, P_WIN  = 3'd4, P_LOSE = 3'd5
  } pat_e;

  state_e      state_q, state_d;
  pat_e        pat_q, pat_d;
  code_e       code_q, code_d;
  logic [2:0]  step_q, step_d;
  logic [31:0] note_q, note_d;
  logic [31:0] half_q, half_d;
  logic        piezo_q, piezo_d;
  logic        busy_q, busy_d;

  pat_e        new_pat;
  logic        lvl_start;
  logic        tone_rst;
  logic [31:0] half_lim;

  function automatic code_e step_code(input pat_e pat, input logic [2:0] step);
    case (pat)
      P_OK:    return (step == 3'd1) ? C_SIL : C_HI;
      P_WIN:   return (step == 3'd0 || step == 3'd2) ? C_LO : C_HI;
      P_LOSE:  return C_LO;
      default: return C_SIL;
    endcase
  endfunction

  function automatic logic [2:0] last_step(input pat_e pat);
    case (pat)
      P_OK:    return 3'd2;
      P_WIN:   return 3'd5;
      default: return 3'd7;
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    code_d    = code_q;
    step_d    = step_q;
    note_d    = note_q;
    half_d    = half_q;
    piezo_d   = piezo_q;
    busy_d    = busy_q;
    lvl_start = 1'b0;
    tone_rst  = 1'b0;
    half_lim  = (code_q == C_HI) ? 32'(HALF_HI - 1) : 32'(HALF_LO - 1);

    if (code_q == C_SIL) begin
      half_d  = '0;
      piezo_d = 1'b0;
    end else if (half_q == half_lim) begin
      half_d  = '0;
      piezo_d = ~piezo_q;
    end else begin
      half_d  = half_q + 32'd1;
    end

    if (lose_pulse)     new_pat = P_LOSE;
    else if (win_pulse) new_pat = P_WIN;
    else if (ok_pulse)  new_pat = P_OK;
    else                new_pat = P_IDLE;

    case (state_q)
      S_IDLE: lvl_start = 1'b1;
      S_LEVEL: begin
        // Re-arbitrate whenever the playing level no longer matches the preferred one.
        if (!warn_level && !beep_level) begin
          lvl_start = 1'b1;
        end else if (warn_level != (pat_q == P_WARN)) begin
          lvl_start = 1'b1;
        end else if (pat_q == P_WARN) begin
          if (note_q == 32'(NOTE_TICKS - 1)) begin
            note_d   = '0;
            code_d   = (code_q == C_HI) ? C_LO : C_HI;
            tone_rst = 1'b1;
          end else begin
            note_d   = note_q + 32'd1;
          end
        end
      end
      S_ONESHOT: begin
        if (note_q == 32'(NOTE_TICKS - 1)) begin
          note_d = '0;
          if (step_q == last_step(pat_q)) begin
            lvl_start = 1'b1;
          end else begin
            step_d = step_q + 3'd1;
            code_d = step_code(pat_q, step_q + 3'd1);
            if (code_d != code_q) tone_rst = 1'b1;
          end
        end else begin
          note_d = note_q + 32'd1;
        end
      end
      default: lvl_start = 1'b1;
    endcase

    if (lvl_start) begin
      step_d   = '0;
      note_d   = '0;
      busy_d   = 1'b0;
      tone_rst = 1'b1;
      if (warn_level) begin
        state_d = S_LEVEL; pat_d = P_WARN; code_d = C_HI;
      end else if (beep_level) begin
        state_d = S_LEVEL; pat_d = P_BEEP; code_d = C_LO;
      end else begin
        state_d = S_IDLE;  pat_d = P_IDLE; code_d = C_SIL;
      end
    end

    // Equal or higher priority pulse restarts the one-shot from step 0.
    if (new_pat != P_IDLE && (state_q != S_ONESHOT || new_pat >= pat_q)) begin
      state_d  = S_ONESHOT;
      pat_d    = new_pat;
      code_d   = step_code(new_pat, 3'd0);
      step_d   = '0;
      note_d   = '0;
      busy_d   = 1'b1;
      tone_rst = 1'b1;
    end

    if (tone_rst) begin
      half_d  = '0;
      piezo_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (sys_rst || !enable) begin
      state_q <= S_IDLE;
      pat_q   <= P_IDLE;
      code_q  <= C_SIL;
      step_q  <= '0;
      note_q  <= '0;
      half_q  <= '0;
      piezo_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      code_q  <= code_d;
      step_q  <= step_d;
      note_q  <= note_d;
      half_q  <= half_d;
      piezo_q <= piezo_d;
      busy_q  <= busy_d;
    end
  end

  assign piezo_out  = piezo_q;
  assign busy       = busy_q;
  assign pattern_id = pat_q;

endmodule

// File: tb/tb_piezo_alert_sequencer.sv
// Directed scenarios for piezo_alert_sequencer with a cycle-stamped scoreboard
// of expected outputs (HALF_HI=5, HALF_LO=10, NOTE_TICKS=40).
module tb_piezo_alert_sequencer;

  logic       clk = 1'b0;
  logic       sys_rst, enable, beep_level, warn_level;
  logic       ok_pulse, win_pulse, lose_pulse;
  logic       piezo_out, busy;
  logic [2:0] pattern_id;

  typedef struct {
    int         cyc;
    logic       p;
    logic       b;
    logic [2:0] id;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  piezo_alert_sequencer #(
    .CLK_FREQ_HZ(1000),
    .TONE_HI_HZ (100),
    .TONE_LO_HZ (50),
    .NOTE_TICKS (40)
  ) dut (
    .clk       (clk),
    .sys_rst   (sys_rst),
    .enable    (enable),
    .beep_level(beep_level),
    .warn_level(warn_level),
    .ok_pulse  (ok_pulse),
    .win_pulse (win_pulse),
    .lose_pulse(lose_pulse),
    .piezo_out (piezo_out),
    .busy      (busy),
    .pattern_id(pattern_id)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        total++;
        if (sb[i].cyc < cyc) begin
          bad++;
          $error("FAIL %s expired: cyc=%0d never checked (now %0d)", sb[i].tag, sb[i].cyc, cyc);
        end else begin
          assert ({piezo_out, busy, pattern_id} === {sb[i].p, sb[i].b, sb[i].id}) else begin
            bad++;
            $error("FAIL %s cyc=%0d got piezo=%b busy=%b id=%0d exp piezo=%b busy=%b id=%0d",
                   sb[i].tag, cyc, piezo_out, busy, pattern_id, sb[i].p, sb[i].b, sb[i].id);
          end
        end
        sb.delete(i);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expect a tone of half-period 'half' (0 = silent) restarting low at cyc+start.
  task automatic push_tone(input int start, input int len, input int half,
                           input logic b, input logic [2:0] id, input string tag);
    exp_t e;
    for (int i = 0; i < len; i++) begin
      e.cyc = cyc + start + i;
      e.p   = (half == 0) ? 1'b0 : logic'((i / half) % 2);
      e.b   = b;
      e.id  = id;
      e.tag = tag;
      sb.push_back(e);
    end
  endtask

  initial begin
    sys_rst = 1'b1; enable = 1'b1; beep_level = 1'b0; warn_level = 1'b0;
    ok_pulse = 1'b0; win_pulse = 1'b0; lose_pulse = 1'b0;
    tick(3);
    sys_rst = 1'b0;
    push_tone(0, 200, 0, 1'b0, 3'd0, "idle");
    tick(200);

    push_tone(1, 60, 10, 1'b0, 3'd1, "beep");
    beep_level = 1'b1;
    tick(60);
    push_tone(1, 20, 0, 1'b0, 3'd0, "beep_off");
    beep_level = 1'b0;
    tick(20);

    push_tone(1,   40, 5, 1'b1, 3'd3, "ok_s0");
    push_tone(41,  40, 0, 1'b1, 3'd3, "ok_s1");
    push_tone(81,  40, 5, 1'b1, 3'd3, "ok_s2");
    push_tone(121, 10, 0, 1'b0, 3'd0, "ok_end");
    ok_pulse = 1'b1; tick(1); ok_pulse = 1'b0;
    tick(130);

    beep_level = 1'b1;
    tick(5);
    push_tone(1,   320, 10, 1'b1, 3'd5, "lose_pre");
    push_tone(321, 30,  10, 1'b0, 3'd1, "beep_resume");
    lose_pulse = 1'b1; tick(1); lose_pulse = 1'b0;
    tick(355);
    beep_level = 1'b0;
    tick(5);

    push_tone(1,   40,  10, 1'b1, 3'd4, "win_s0");
    push_tone(41,  40,  5,  1'b1, 3'd4, "win_s1");
    push_tone(81,  40,  10, 1'b1, 3'd4, "win_s2");
    push_tone(121, 120, 5,  1'b1, 3'd4, "win_s345");
    push_tone(241, 10,  0,  1'b0, 3'd0, "win_end");
    win_pulse = 1'b1; tick(1); win_pulse = 1'b0;
    tick(49);
    ok_pulse = 1'b1; tick(1); ok_pulse = 1'b0;
    tick(210);

    push_tone(1,   40,  10, 1'b1, 3'd4, "win2_s0");
    push_tone(41,  20,  5,  1'b1, 3'd4, "win2_s1");
    push_tone(61,  320, 10, 1'b1, 3'd5, "lose_restart");
    push_tone(381, 10,  0,  1'b0, 3'd0, "lose_end");
    win_pulse = 1'b1; tick(1); win_pulse = 1'b0;
    tick(59);
    lose_pulse = 1'b1; tick(1); lose_pulse = 1'b0;
    tick(330);

    push_tone(1,  10, 5, 1'b1, 3'd3, "ok_pre_rst");
    push_tone(11, 5,  0, 1'b0, 3'd0, "rst_mid");
    ok_pulse = 1'b1; tick(1); ok_pulse = 1'b0;
    tick(9);
    sys_rst = 1'b1; tick(2); sys_rst = 1'b0;
    tick(4);

    push_tone(1,  40, 5,  1'b0, 3'd2, "warn_hi");
    push_tone(41, 20, 10, 1'b0, 3'd2, "warn_lo");
    warn_level = 1'b1;
    tick(60);
    push_tone(1, 20, 0, 1'b0, 3'd0, "mute");
    enable = 1'b0;
    tick(5);
    ok_pulse = 1'b1; tick(1); ok_pulse = 1'b0;
    tick(14);
    push_tone(1,  40, 5,  1'b0, 3'd2, "warn_re_hi");
    push_tone(41, 10, 10, 1'b0, 3'd2, "warn_re_lo");
    enable = 1'b1;
    tick(55);
    warn_level = 1'b0;
    tick(3);

    total++;
    assert (sb.size() == 0) else begin
      bad++;
      $error("FAIL sb_drain got %0d pending entries exp 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
